// File: rtl/matrix_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_driver_pkg
//  Brief    : Shared scan-state encoding and pin polarity helpers for the
//             multiplexed LED-matrix scanner.
//  Revision : 1.0  initial release
// ============================================================================
package matrix_scan_driver_pkg;

    // Scan slot phases: blanking (everything dark) then the lit PWM window.
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    // Map a logical "active" flag onto the physical pin level.
    function automatic logic pin_level(input logic active, input logic act_lo);
        return act_lo ? ~active : active;
    endfunction

    // Row drive level for a row that is (or is not) selected.
    function automatic logic row_level(input logic selected, input logic row_act_lo);
        return pin_level(selected, row_act_lo);
    endfunction

    // Column drive level for a column that is (or is not) lit.
    function automatic logic col_level(input logic lit, input logic col_act_lo);
        return pin_level(lit, col_act_lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_driver_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_driver_scan_timer
//  Brief    : Row/phase sequencer. Each row gets BLANK dark cycles followed by
//             2**PWM_BITS lit cycles; flags the first cycle and the last cycle
//             of every frame. Held at row 0, first blank cycle while disabled.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_scan_driver_scan_timer
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int BLANK    = 1,
    parameter int PWM_BITS = 2,
    parameter int ROW_W    = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    output logic [ROW_W-1:0]    o_row,
    output logic                o_is_on,
    output logic [PWM_BITS-1:0] o_pwm,
    output logic                o_frame_start,
    output logic                o_frame_end
);

    localparam int c_on_len  = 2 ** PWM_BITS;
    localparam int c_cnt_max = (BLANK > c_on_len) ? BLANK : c_on_len;
    localparam int c_cnt_w   = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK - 1);
    localparam logic [c_cnt_w-1:0] c_on_last    = c_cnt_w'(c_on_len - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [ROW_W-1:0]   c_row_last   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   c_row_one    = ROW_W'(1);

    logic [ROW_W-1:0]   r_row;
    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic [ROW_W-1:0]   w_row_nxt;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    // Scan position register; reset and disable both park it at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_state <= ST_BLANK;
            r_cnt   <= '0;
        end else begin
            r_row   <= w_row_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Advance blank -> on -> next row; the counter is reused for both phases.
    always_comb begin
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        if (!i_enable) begin
            w_row_nxt   = '0;
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_BLANK) begin
            if (r_cnt == c_blank_last) begin
                w_state_nxt = ST_ON;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (r_cnt == c_on_last) begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_row_nxt   = (r_row == c_row_last) ? '0 : r_row + c_row_one;
            end
        end
    end

    assign o_row         = r_row;
    assign o_is_on       = (r_state == ST_ON);
    assign o_pwm         = r_cnt[PWM_BITS-1:0];
    assign o_frame_start = i_enable && (r_row == '0) && (r_state == ST_BLANK) && (r_cnt == '0);
    assign o_frame_end   = i_enable && (r_row == c_row_last) && (r_state == ST_ON) && (r_cnt == c_on_last);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_driver
//  Brief    : Multiplexed LED-matrix scanner with anti-ghost blanking, global
//             PWM brightness and a double-buffered (tear-free) frame load.
//  Revision : 1.0  initial release
// ============================================================================
module matrix_scan_driver
    import matrix_scan_driver_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int BLANK      = 1,
    parameter int PWM_BITS   = 2,
    parameter int ROW_ACT_LO = 1,
    parameter int COL_ACT_LO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PWM_BITS-1:0]  brightness,
    input  logic [ROWS*COLS-1:0] pix_in,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic [ROWS-1:0]      row_out,
    output logic [COLS-1:0]      col_out,
    output logic                 frame_start
);

    localparam int c_row_w = $clog2(ROWS);
    localparam int c_pix_w = ROWS * COLS;

    localparam logic c_row_lo = (ROW_ACT_LO != 0);
    localparam logic c_col_lo = (COL_ACT_LO != 0);
    localparam logic [ROWS-1:0] c_row_idle = c_row_lo ? {ROWS{1'b1}} : {ROWS{1'b0}};
    localparam logic [COLS-1:0] c_col_idle = c_col_lo ? {COLS{1'b1}} : {COLS{1'b0}};

    logic [c_row_w-1:0]  w_row;
    logic                w_is_on;
    logic [PWM_BITS-1:0] w_pwm;
    logic                w_frame_start;
    logic                w_frame_end;

    logic [c_pix_w-1:0]  r_disp;
    logic [c_pix_w-1:0]  r_pending;
    logic                r_pending_full;
    logic [PWM_BITS-1:0] r_bq;
    logic                r_en_prev;

    logic                w_boundary;
    logic                w_swap;
    logic                w_accept;
    logic                w_show;
    logic [COLS-1:0]     w_disp_rows [ROWS];
    logic [ROWS-1:0]     w_row_nxt;
    logic [COLS-1:0]     w_col_nxt;

    matrix_scan_driver_scan_timer #(
        .ROWS     (ROWS),
        .BLANK    (BLANK),
        .PWM_BITS (PWM_BITS),
        .ROW_W    (c_row_w)
    ) u_scan_timer (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .o_row         (w_row),
        .o_is_on       (w_is_on),
        .o_pwm         (w_pwm),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end)
    );

    // Present the display buffer as one COLS-wide slice per row.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_disp_rows
        assign w_disp_rows[gr] = r_disp[gr*COLS +: COLS];
    end

    // Frame boundary: end of the last row, or the first cycle after enable rises.
    assign w_boundary = enable && (w_frame_end || !r_en_prev);
    assign w_swap     = w_boundary && r_pending_full;
    assign load_ready = !r_pending_full && !rst;
    assign w_accept   = load_valid && load_ready;
    assign w_show     = enable && w_is_on;

    // Pin values for the next cycle derived from the current scan position.
    always_comb begin
        w_row_nxt = c_row_idle;
        w_col_nxt = c_col_idle;
        for (int r = 0; r < ROWS; r++) begin
            w_row_nxt[r] = row_level(w_show && (w_row == c_row_w'(r)), c_row_lo);
        end
        for (int c = 0; c < COLS; c++) begin
            w_col_nxt[c] = col_level(w_show && w_disp_rows[w_row][c] && (w_pwm <= r_bq), c_col_lo);
        end
    end

    // Registered pins, one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_out     <= c_row_idle;
            col_out     <= c_col_idle;
            frame_start <= 1'b0;
        end else begin
            row_out     <= w_row_nxt;
            col_out     <= w_col_nxt;
            frame_start <= w_frame_start;
        end
    end

    // Double buffer: swap only at frame boundaries so a frame is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp         <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_bq           <= '0;
            r_en_prev      <= 1'b0;
        end else begin
            r_en_prev <= enable;
            if (w_boundary) begin
                r_bq <= brightness;
            end
            if (w_swap) begin
                r_disp         <= r_pending;
                r_pending_full <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= pix_in;
                r_pending_full <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_driver
//  Brief    : Self-checking bench for matrix_scan_driver against a frame-level
//             behavioural model (position-in-frame arithmetic, two buffers).
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_scan_driver;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int BLANK      = 1;
    localparam int PWM_BITS   = 2;
    localparam int ROW_ACT_LO = 1;
    localparam int COL_ACT_LO = 0;
    localparam int SLOT       = BLANK + (1 << PWM_BITS);
    localparam int FRAME      = ROWS * SLOT;
    localparam int NPIX       = ROWS * COLS;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic [PWM_BITS-1:0] brightness = '0;
    logic [NPIX-1:0]     pix_in = '0;
    logic                load_valid = 1'b0;
    logic                load_ready;
    logic [ROWS-1:0]     row_out;
    logic [COLS-1:0]     col_out;
    logic                frame_start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int              m_pos = 0;
    bit              m_en_prev = 1'b0;
    logic [NPIX-1:0] m_disp = '0;
    logic [NPIX-1:0] m_pend = '0;
    bit              m_full = 1'b0;
    int              m_bq = 0;
    logic [ROWS-1:0] m_row = '1;
    logic [COLS-1:0] m_col = '0;
    logic            m_fs = 1'b0;

    matrix_scan_driver #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .BLANK      (BLANK),
        .PWM_BITS   (PWM_BITS),
        .ROW_ACT_LO (ROW_ACT_LO),
        .COL_ACT_LO (COL_ACT_LO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .brightness  (brightness),
        .pix_in      (pix_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .row_out     (row_out),
        .col_out     (col_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Predict the pins for the coming edge from the current inputs, then clock.
    task automatic tick();
        logic [ROWS-1:0] rmask;
        logic [COLS-1:0] cmask;
        bit              rdy;
        int              r;
        int              k;
        rmask = '0;
        cmask = '0;
        if (rst) begin
            m_pos = 0; m_en_prev = 1'b0; m_disp = '0; m_pend = '0;
            m_full = 1'b0; m_bq = 0; m_fs = 1'b0;
        end else begin
            rdy  = !m_full;
            m_fs = 1'b0;
            if (enable) begin
                r = m_pos / SLOT;
                k = m_pos % SLOT;
                if (k >= BLANK) begin
                    rmask[r] = 1'b1;
                    for (int c = 0; c < COLS; c++)
                        if (m_disp[r*COLS + c] && (k - BLANK) <= m_bq) cmask[c] = 1'b1;
                end
                m_fs = (m_pos == 0);
                if (m_pos == FRAME - 1 || !m_en_prev) begin
                    m_bq = int'(brightness);
                    if (m_full) begin
                        m_disp = m_pend;
                        m_full = 1'b0;
                    end
                end
                m_pos = (m_pos + 1) % FRAME;
            end else begin
                m_pos = 0;
            end
            if (load_valid && rdy) begin
                m_pend = pix_in;
                m_full = 1'b1;
            end
            m_en_prev = enable;
        end
        m_row = (ROW_ACT_LO != 0) ? ~rmask : rmask;
        m_col = (COL_ACT_LO != 0) ? ~cmask : cmask;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (row_out !== {ROWS{1'b1}} || col_out !== '0 || frame_start !== 1'b0 || load_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc=%0d row_out=%b col_out=%b fs=%b rdy=%b required 1111/0000/0/0",
                         cyc, row_out, col_out, frame_start, load_ready);
            end
        end
    endtask

    task automatic test_idle_scan();
        int fs_count = 0;
        rst = 1'b0; enable = 1'b1; brightness = '0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_start === 1'b1) fs_count++;
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL idle_scan cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
        checks++;
        if (fs_count != 2) begin
            failures++;
            $display("FAIL idle_frame_start_count got=%0d required=2", fs_count);
        end
    endtask

    task automatic test_load_basic();
        brightness = 2'd3;
        pix_in = 16'h8421;
        load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            tick();
            load_valid = 1'b0;
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL load_basic cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
    endtask

    task automatic test_brightness();
        // Land mid-frame before changing the duty level.
        for (int i = 0; i < 7; i++) tick();
        brightness = 2'd0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL brightness cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [NPIX-1:0] a;
        logic [NPIX-1:0] b;
        bit took;
        a = NPIX'($urandom);
        b = NPIX'($urandom);
        brightness = 2'($urandom_range(0, 3));
        pix_in = a; load_valid = 1'b1;
        took = load_ready;
        tick();
        pix_in = b;
        for (int i = 0; i < 3 * FRAME; i++) begin
            took = load_ready;
            tick();
            if (took) load_valid = 1'b0;
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_load_on_frame_end();
        int guard = 0;
        while (!(m_pos == FRAME - 1 && !m_full) && guard < 3 * FRAME) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 3 * FRAME) begin
            failures++;
            $display("FAIL frame_end_wait timeout after %0d cycles required < %0d", guard, 3 * FRAME);
        end
        pix_in = NPIX'($urandom) | 16'h0001;
        load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            tick();
            load_valid = 1'b0;
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL load_on_frame_end cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
    endtask

    task automatic test_enable_toggle();
        int guard = 0;
        brightness = 2'd3;
        while (m_pos != 2 * SLOT + 2 && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        enable = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            if (i == 2) begin pix_in = NPIX'($urandom); load_valid = 1'b1; end
            if (i == 4) enable = 1'b1;
            tick();
            if (i == 2) load_valid = 1'b0;
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL enable_toggle cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
    endtask

    task automatic test_reset_mid();
        pix_in = '1; load_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin tick(); load_valid = 1'b0; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (row_out !== {ROWS{1'b1}} || col_out !== '0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pins row=%b col=%b fs=%b required 1111/0000/0", row_out, col_out, frame_start);
        end
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            enable     = ($urandom_range(0, 15) != 0);
            brightness = PWM_BITS'($urandom);
            pix_in     = NPIX'($urandom);
            load_valid = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (row_out !== m_row || col_out !== m_col || frame_start !== m_fs || load_ready !== (!rst && !m_full)) begin
                failures++;
                $display("FAIL random cyc=%0d row=%b exp=%b col=%b exp=%b fs=%b exp=%b rdy=%b exp=%b",
                         cyc, row_out, m_row, col_out, m_col, frame_start, m_fs, load_ready, !m_full);
            end
        end
        rst = 1'b0; enable = 1'b1; load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_basic();
        test_brightness();
        test_back_to_back();
        test_load_on_frame_end();
        test_enable_toggle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
